// File: rtl/flux_stim_pkg.sv
// flux_stim_pkg: shared definitions for the synthetic flux-transition generator.
//   - stim_state_t : FSM state encoding (also exported on state_out)
//   - LFSR_MASK    : Galois feedback mask of the jitter LFSR
//   - JITTER_MAX   : largest jitter width honoured (wider requests saturate)
//   - FREQ_MIN/MAX : legal range of the latched NCO increment
package flux_stim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_DRAIN    = 2'd3
  } stim_state_t;

  localparam logic [15:0] LFSR_MASK  = 16'hB400;
  localparam int unsigned JITTER_MAX = 4;
  localparam logic [31:0] FREQ_MIN   = 32'h0000_0001;
  localparam logic [31:0] FREQ_MAX   = 32'h7FFF_FFFF;

  // Keeps the increment non-zero and below half scale, so every cell has
  // exactly one accumulator midpoint crossing and one carry.
  function automatic logic [31:0] clamp_freq(input logic [31:0] f);
    if (f < FREQ_MIN) return FREQ_MIN;
    if (f > FREQ_MAX) return FREQ_MAX;
    return f;
  endfunction

  // Low-bit mask selecting k = min(sel, JITTER_MAX) LFSR bits.
  function automatic logic [3:0] jitter_mask(input logic [2:0] sel);
    if (32'(sel) >= JITTER_MAX) return 4'hF;
    return (4'h1 << sel) - 4'h1;
  endfunction

endpackage

// File: rtl/stim_lfsr16.sv
// stim_lfsr16: 16-bit Galois LFSR used as the jitter source.
//   clk   : system clock
//   reset : synchronous active-high, loads SEED
//   load  : reload SEED (start of a new stimulus run)
//   step  : advance one position
//   value : current LFSR contents
module stim_lfsr16
  import flux_stim_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  output logic [15:0] value
);

  always_ff @(posedge clk) begin
    if (reset || load) begin
      value <= SEED;
    end else if (step) begin
      value <= {1'b0, value[15:1]} ^ (value[0] ? LFSR_MASK : '0);
    end
  end

endmodule

// File: rtl/flux_stim_gen.sv
// flux_stim_gen: synthetic MFM-style flux pulse generator for DPLL tests.
// A 32-bit NCO defines the bit cell (cell ends on accumulator carry); a pulse
// is triggered at the cell midpoint (acc[31] rising) for 1-cells, delayed by
// an LFSR-derived jitter of 0..2^k-1 clocks, and held high PULSE_W clocks.
// A preamble of alternating 1/0 cells precedes the repeated 16-bit pattern.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   start, abort    : run request (IDLE only) / forced return to IDLE
//   freq_word       : NCO increment (clamped to 1..2^31-1 when latched)
//   pattern         : data pattern, MSB first, repeated
//   cell_count      : data cells after preamble, 0 = until abort
//   jitter_sel      : jitter width k (values above 4 act as 4)
//   flux_out        : flux pulse
//   cell_strobe     : one-cycle pulse per completed cell
//   busy, done      : run active / normal completion pulse
//   overrun         : sticky, a trigger was dropped
//   cells_sent, pulses_sent : saturating run counters
//   state_out       : FSM state
module flux_stim_gen
  import flux_stim_pkg::*;
#(
  parameter int unsigned PULSE_W        = 4,
  parameter int unsigned PREAMBLE_CELLS = 64,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] freq_word,
  input  logic [15:0] pattern,
  input  logic [15:0] cell_count,
  input  logic [2:0]  jitter_sel,
  output logic        flux_out,
  output logic        cell_strobe,
  output logic        busy,
  output logic        done,
  output logic        overrun,
  output logic [31:0] cells_sent,
  output logic [31:0] pulses_sent,
  output logic [1:0]  state_out
);

  localparam logic [3:0]  PW_LOAD  = 4'(PULSE_W - 1);
  localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_CELLS - 1);

  stim_state_t state, state_nxt;

  logic [31:0] acc;
  logic [31:0] freq_l;
  logic        acc31_q;
  logic [15:0] pattern_l;
  logic [15:0] ccount_l;
  logic [2:0]  jsel_l;
  logic [15:0] pre_idx;
  logic [15:0] data_idx;
  logic        dly_active;
  logic [3:0]  dly_cnt;
  logic [3:0]  pw_cnt;
  logic [15:0] lfsr_val;
  logic        unused_lfsr_hi;

  logic        running;
  logic [32:0] sum;
  logic        carry;
  logic        cur_bit;
  logic        trig;
  logic        engine_busy;
  logic        accept;
  logic        drop;
  logic [3:0]  jit_delay;
  logic        pulse_rise;
  logic        start_acc;
  logic        abort_hit;
  logic        pre_last;
  logic        data_last;
  logic        done_nxt;

  stim_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (start_acc),
    .step  (accept),
    .value (lfsr_val)
  );

  assign unused_lfsr_hi = ^lfsr_val[15:4];

  always_comb begin
    running     = (state == ST_PREAMBLE) || (state == ST_DATA);
    sum         = {1'b0, acc} + {1'b0, freq_l};
    carry       = running && sum[32];
    cur_bit     = (state == ST_PREAMBLE) ? ~pre_idx[0] : pattern_l[4'd15 - data_idx[3:0]];
    // Midpoint detected one cycle after acc[31] becomes set.
    trig        = running && acc[31] && !acc31_q && cur_bit;
    engine_busy = dly_active || flux_out;
    accept      = trig && !engine_busy;
    drop        = trig && engine_busy;
    jit_delay   = lfsr_val[3:0] & jitter_mask(jsel_l);
    pulse_rise  = (dly_active && (dly_cnt == 4'd1)) || (accept && (jit_delay == 4'd0));
    start_acc   = (state == ST_IDLE) && start && !abort;
    abort_hit   = (state != ST_IDLE) && abort;
    pre_last    = (pre_idx == PRE_LAST);
    data_last   = (ccount_l != 16'd0) && (data_idx == ccount_l - 16'd1);
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE:     if (start_acc) state_nxt = ST_PREAMBLE;
      ST_PREAMBLE: if (abort) state_nxt = ST_IDLE;
                   else if (carry && pre_last) state_nxt = ST_DATA;
      ST_DATA:     if (abort) state_nxt = ST_IDLE;
                   else if (carry && data_last) state_nxt = ST_DRAIN;
      ST_DRAIN:    if (abort) state_nxt = ST_IDLE;
                   else if (!engine_busy) begin
                     state_nxt = ST_IDLE;
                     done_nxt  = 1'b1;
                   end
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc         <= '0;
      acc31_q     <= 1'b0;
      freq_l      <= '0;
      pattern_l   <= '0;
      ccount_l    <= '0;
      jsel_l      <= '0;
      pre_idx     <= '0;
      data_idx    <= '0;
      dly_active  <= 1'b0;
      dly_cnt     <= '0;
      pw_cnt      <= '0;
      flux_out    <= 1'b0;
      cell_strobe <= 1'b0;
      done        <= 1'b0;
      overrun     <= 1'b0;
      cells_sent  <= '0;
      pulses_sent <= '0;
    end else begin
      cell_strobe <= 1'b0;
      done        <= done_nxt;
      if (start_acc) begin
        freq_l      <= clamp_freq(freq_word);
        pattern_l   <= pattern;
        ccount_l    <= cell_count;
        jsel_l      <= jitter_sel;
        acc         <= '0;
        acc31_q     <= 1'b0;
        pre_idx     <= '0;
        data_idx    <= '0;
        dly_active  <= 1'b0;
        dly_cnt     <= '0;
        pw_cnt      <= '0;
        flux_out    <= 1'b0;
        overrun     <= 1'b0;
        cells_sent  <= '0;
        pulses_sent <= '0;
      end else if (abort_hit) begin
        flux_out   <= 1'b0;
        dly_active <= 1'b0;
        pw_cnt     <= '0;
      end else begin
        if (running) begin
          acc     <= sum[31:0];
          acc31_q <= acc[31];
          if (carry) begin
            cell_strobe <= 1'b1;
            if (cells_sent != '1) cells_sent <= cells_sent + 32'd1;
            if (state == ST_PREAMBLE) pre_idx  <= pre_idx + 16'd1;
            else                      data_idx <= data_idx + 16'd1;
          end
        end
        // accept only fires with the engine idle, so it never collides with
        // the countdown/width branches below.
        if (pulse_rise) begin
          flux_out   <= 1'b1;
          pw_cnt     <= PW_LOAD;
          dly_active <= 1'b0;
          if (pulses_sent != '1) pulses_sent <= pulses_sent + 32'd1;
        end else if (flux_out) begin
          if (pw_cnt == 4'd0) flux_out <= 1'b0;
          else                pw_cnt   <= pw_cnt - 4'd1;
        end else if (dly_active) begin
          dly_cnt <= dly_cnt - 4'd1;
        end
        if (accept && (jit_delay != 4'd0)) begin
          dly_active <= 1'b1;
          dly_cnt    <= jit_delay;
        end
        if (drop) overrun <= 1'b1;
      end
    end
  end

  assign busy      = (state != ST_IDLE);
  assign state_out = state;

endmodule

// File: tb/tb_flux_stim_gen.sv
// tb_flux_stim_gen: randomized and directed self-checking bench for
// flux_stim_gen. The reference model works from NCO arithmetic (n*f) and a
// per-pulse occupancy window rather than cycle-stepped state.
module tb_flux_stim_gen;

  localparam int          PW   = 4;
  localparam int          PRE  = 64;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [31:0] freq_word;
  logic [15:0] pattern, cell_count;
  logic [2:0]  jitter_sel;
  logic        flux_out, cell_strobe, busy, done, overrun;
  logic [31:0] cells_sent, pulses_sent;
  logic [1:0]  state_out;

  flux_stim_gen #(.PULSE_W(PW), .PREAMBLE_CELLS(PRE), .LFSR_SEED(SEED)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .freq_word   (freq_word),
    .pattern     (pattern),
    .cell_count  (cell_count),
    .jitter_sel  (jitter_sel),
    .flux_out    (flux_out),
    .cell_strobe (cell_strobe),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun),
    .cells_sent  (cells_sent),
    .pulses_sent (pulses_sent),
    .state_out   (state_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  longint exp_rise[$];
  longint exp_nom[$];
  longint obs_rise[$];
  longint saved_rise[$];
  longint exp_pulses, exp_cells, exp_done;
  bit     exp_overrun;
  bit [7:0] jit_seen;
  int       jit_bad;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Expected behaviour from the cell/midpoint arithmetic. Cycle 0 is the
  // cycle right after the start edge; acc after n updates is n*f mod 2^32.
  task automatic model_run(input logic [31:0] f_raw, input logic [15:0] pat,
                           input int cc, input int js, input int abort_at);
    longint f, total, n_end, limit, busy_end, c, d, rise;
    logic [15:0] lf;
    int k, bitv;
    f = f_raw;
    if (f == 0) f = 1;
    if (f > 64'h7FFF_FFFF) f = 64'h7FFF_FFFF;
    k = (js > 4) ? 4 : js;
    total = PRE + cc;
    n_end = (cc == 0) ? 64'h7FFF_FFFF : (total * (64'd1 << 32) + f - 1) / f;
    limit = (abort_at > 0) ? abort_at : n_end;
    exp_rise.delete();
    exp_nom.delete();
    busy_end = 0;
    lf = SEED;
    exp_pulses = 0;
    exp_overrun = 0;
    for (longint n = 1; n < limit; n++) begin
      if ((((n * f) >> 31) & 1) == 1 && ((((n - 1) * f) >> 31) & 1) == 0) begin
        c = (n * f) >> 32;
        if (c < PRE) bitv = (c % 2 == 0) ? 1 : 0;
        else         bitv = int'((pat >> (15 - ((c - PRE) % 16))) & 16'h1);
        if (bitv == 1) begin
          if (n <= busy_end) begin
            exp_overrun = 1;
          end else begin
            d = longint'(lf) & ((64'd1 << k) - 1);
            lf = lfsr_next(lf);
            rise = n + 1 + d;
            busy_end = n + d + PW;
            if (abort_at == 0 || rise <= abort_at) begin
              exp_rise.push_back(rise);
              exp_nom.push_back(n);
              exp_pulses++;
            end
          end
        end
      end
    end
    if (abort_at > 0) begin
      exp_cells = (longint'(abort_at) * f) >> 32;
      exp_done  = -1;
    end else begin
      exp_cells = total;
      exp_done  = ((n_end > busy_end + 1) ? n_end : busy_end + 1) + 1;
    end
  endtask

  task automatic check_all_zero(input string name);
    check_eq({name, "/flux"}, flux_out, 0);
    check_eq({name, "/strobe"}, cell_strobe, 0);
    check_eq({name, "/busy"}, busy, 0);
    check_eq({name, "/done"}, done, 0);
    check_eq({name, "/overrun"}, overrun, 0);
    check_eq({name, "/cells"}, cells_sent, 0);
    check_eq({name, "/pulses"}, pulses_sent, 0);
    check_eq({name, "/state"}, state_out, 0);
  endtask

  task automatic run_case(input string name, input logic [31:0] f_raw, input logic [15:0] pat,
                          input int cc, input int js, input int abort_at,
                          input int reset_at, input int poke_at);
    int budget, done_cyc, width, wmin, wmax, nw, strobes, bad, quiet;
    longint fo, fe, off;
    logic prev;
    bit ended;
    model_run(f_raw, pat, cc, js, abort_at);
    if (abort_at > 0)      budget = abort_at;
    else if (reset_at > 0) budget = reset_at;
    else                   budget = int'(exp_done) + 10;
    freq_word = f_raw; pattern = pat; cell_count = 16'(cc); jitter_sel = 3'(js);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq({name, "/start_state"}, state_out, 1);
    check_eq({name, "/start_cleared"}, {overrun, cells_sent, pulses_sent}, 0);
    obs_rise.delete();
    prev = 1'b0; width = 0; wmin = 999; wmax = 0; nw = 0; strobes = 0;
    done_cyc = -1; ended = 0;
    for (int c = 0; c <= budget; c++) begin
      if (flux_out && !prev) obs_rise.push_back(c);
      if (flux_out) width++;
      else if (prev) begin
        if (width < wmin) wmin = width;
        if (width > wmax) wmax = width;
        nw++;
        width = 0;
      end
      prev = flux_out;
      if (cell_strobe) strobes++;
      if (done) begin
        done_cyc = c;
        break;
      end
      if (abort_at > 0 && c == abort_at) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq({name, "/abort_state"}, state_out, 0);
        check_eq({name, "/abort_flux"}, flux_out, 0);
        check_eq({name, "/abort_busy"}, busy, 0);
        check_eq({name, "/abort_cells"}, cells_sent, exp_cells);
        check_eq({name, "/abort_pulses"}, pulses_sent, exp_pulses);
        check_eq({name, "/abort_strobes"}, strobes, exp_cells);
        quiet = 0;
        for (int i = 0; i < 20; i++) begin
          if (done || flux_out) quiet++;
          tick();
        end
        check_eq({name, "/abort_quiet"}, quiet, 0);
        check_eq({name, "/abort_hold"}, cells_sent, exp_cells);
        ended = 1;
        break;
      end
      if (reset_at > 0 && c == reset_at) begin
        check_eq({name, "/pre_reset_state"}, state_out, 2);
        reset = 1'b1;
        tick();
        check_all_zero({name, "/reset"});
        reset = 1'b0;
        ended = 1;
        break;
      end
      if (poke_at > 0 && c == poke_at) begin
        start = 1'b1; freq_word = 32'h7FFF_FFFF; pattern = ~pat;
        cell_count = 16'd1; jitter_sel = 3'd0;
      end else begin
        start = 1'b0; freq_word = f_raw; pattern = pat;
        cell_count = 16'(cc); jitter_sel = 3'(js);
      end
      tick();
    end
    start = 1'b0;
    // Pulse rise times against the model (only up to the reset point for a reset run).
    bad = 0; fo = 0; fe = 0;
    for (int i = 0; i < obs_rise.size() && i < exp_rise.size(); i++) begin
      if (obs_rise[i] != exp_rise[i]) begin
        if (bad == 0) begin fo = obs_rise[i]; fe = exp_rise[i]; end
        bad++;
      end else begin
        off = obs_rise[i] - exp_nom[i] - 1;
        if (off >= 0 && off < 8) jit_seen[off] = 1'b1;
        else jit_bad++;
      end
    end
    check_eq($sformatf("%s/rise_diffs (first got %0d want %0d)", name, fo, fe), bad, 0);
    if (nw > 0) begin
      check_eq({name, "/width_min"}, wmin, PW);
      check_eq({name, "/width_max"}, wmax, PW);
    end
    if (!ended) begin
      check_eq({name, "/rise_count"}, obs_rise.size(), exp_rise.size());
      check_eq({name, "/done_cycle"}, done_cyc, exp_done);
      check_eq({name, "/cells"}, cells_sent, exp_cells);
      check_eq({name, "/strobes"}, strobes, exp_cells);
      check_eq({name, "/pulses"}, pulses_sent, exp_pulses);
      check_eq({name, "/overrun"}, overrun, exp_overrun);
      check_eq({name, "/end_state"}, state_out, 0);
      check_eq({name, "/end_busy"}, busy, 0);
    end
    tick();
  endtask

  initial begin
    logic [15:0] rp;
    int rc, rj;
    logic [31:0] rf;
    int bad;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    freq_word = '0; pattern = '0; cell_count = '0; jitter_sel = '0;
    jit_seen = '0; jit_bad = 0;
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // Preamble timing, no jitter.
    run_case("pre", 32'h0800_0000, 16'h4489, 16, 0, 0, 0, 0);
    check_eq("pre/first_rise", (obs_rise.size() > 0) ? obs_rise[0] : -1, 17);
    check_eq("pre/spacing", (obs_rise.size() > 1) ? obs_rise[1] - obs_rise[0] : -1, 64);
    check_eq("pre/pulses37", pulses_sent, 37);
    check_eq("pre/cells80", cells_sent, 80);

    // Jitter window coverage.
    jit_seen = '0; jit_bad = 0;
    run_case("jit", 32'h0800_0000, 16'hFFFF, 1000, 3, 0, 0, 0);
    check_eq("jit/offsets_seen", jit_seen, 8'hFF);
    check_eq("jit/offsets_out_of_window", jit_bad, 0);
    check_eq("jit/no_overrun", overrun, 0);
    check_eq("jit/enough_pulses", pulses_sent >= 1000, 1);

    // Overrun with dense 1-cells and wide jitter.
    run_case("ovr", 32'h4000_0000, 16'hFFFF, 64, 4, 0, 0, 0);
    check_eq("ovr/sticky", overrun, 1);
    check_eq("ovr/fewer_pulses", pulses_sent < 96, 1);

    // Abort during an endless run.
    run_case("abort", 32'h0800_0000, 16'($urandom), 0, 2, 500, 0, 0);
    check_eq("abort/cells15", cells_sent, 15);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check_eq("abort_start/state", state_out, 0);
    check_eq("abort_start/busy", busy, 0);

    // Start while busy ignored; restart reproduces the sequence.
    rp = 16'($urandom);
    run_case("poke", 32'h1000_0000, rp, 20, 2, 0, 0, 300);
    saved_rise = obs_rise;
    run_case("restart", 32'h1000_0000, rp, 20, 2, 0, 0, 0);
    bad = 0;
    for (int i = 0; i < saved_rise.size() && i < obs_rise.size(); i++)
      if (saved_rise[i] != obs_rise[i]) bad++;
    check_eq("restart/same_count", obs_rise.size(), saved_rise.size());
    check_eq("restart/same_times", bad, 0);

    // Reset mid-DATA.
    run_case("rst", 32'h0800_0000, 16'hA5A5, 40, 1, 0, 2300, 0);

    // Clamp of an oversized increment.
    run_case("clamp", 32'hFFFF_FFFF, 16'hFFFF, 8, 0, 0, 0, 0);
    check_eq("clamp/first_rise", (obs_rise.size() > 0) ? obs_rise[0] : -1, 3);
    check_eq("clamp/cells72", cells_sent, 72);

    // Randomized runs.
    for (int t = 0; t < 6; t++) begin
      rf = $urandom_range(32'h7FFF_FFFF, 32'h0600_0000);
      rp = 16'($urandom);
      rc = $urandom_range(24, 1);
      rj = $urandom_range(7, 0);
      run_case($sformatf("rnd%0d", t), rf, rp, rc, rj, 0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/flux_stim_gen.md
Name: flux_stim_gen

Overview:
Synthetic flux-transition generator that drives the digital PLL input for closed-loop DPLL characterisation.
- Produces MFM-style flux pulses at a programmable NCO-defined bit-cell rate, with a programmable PPM offset (set through freq_word) and LFSR-driven timing jitter.
- The PLL diagnostics block on the receive side measures the resulting lock time, phase error and histogram.
- Sits ahead of the flux-input mux, selectable in place of the drive read-data line.

Parameters:
- PULSE_W, 4, flux pulse high width in clk cycles (1..15).
- PREAMBLE_CELLS, 64, number of preamble cells sent before pattern data (even, ≥2).
- LFSR_SEED, 16'hACE1, jitter LFSR value loaded at reset and at every start (non-zero).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request; honoured only in IDLE.
- abort  in  1  forces return to IDLE.
- freq_word  in  32  NCO increment per clk; latched at start; bit cell ends on accumulator carry.
- pattern  in  16  data pattern, sent MSB first and repeated; latched at start.
- cell_count  in  16  data cells after the preamble; 0 = run until abort; latched at start.
- jitter_sel  in  3  jitter width k; pulse delay is uniform over 0..2^k−1 clocks; values >4 are treated as 4; latched at start.
- flux_out  out  1  active-high flux pulse.
- cell_strobe  out  1  one-cycle pulse at each cell boundary.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on normal completion.
- overrun  out  1  sticky; a pulse trigger was dropped; cleared at start.
- cells_sent  out  32  cells emitted since the last start.
- pulses_sent  out  32  pulses emitted since the last start.
- state_out  out  2  current FSM state.

Behaviour:
- Reset values: all outputs 0, state IDLE, accumulator 0, LFSR = LFSR_SEED.
- States: IDLE=0, PREAMBLE=1, DATA=2, DRAIN=3.
- Start accepted (IDLE and start=1), on the next edge:
  - latch the config inputs; latched freq_word is clamped to [1, 2^31−1];
  - clear accumulator, counters and overrun; reload LFSR;
  - enter PREAMBLE; cell 0 begins that cycle.
- start while busy: ignored, no side effects.
- NCO: every cycle in PREAMBLE/DATA, 33-bit sum acc + freq_word_l. At carry-out:
  - pulse cell_strobe;
  - increment cells_sent;
  - advance the cell index.
- Current-cell bit:
  - preamble cell i → bit = ~i[0], so cells 0, 2, 4, … carry a pulse;
  - data cell j → bit = pattern_l[15 − (j mod 16)].
- Pulse trigger: acc[31] rises 0→1 (cell midpoint) while the current bit = 1. On trigger:
  - load delay = LFSR[k−1:0] (0 when k=0), then step the LFSR once;
  - LFSR is 16-bit Galois, mask 16'hB400.
- Delay countdown:
  - delay 0 → flux_out rises on the cycle after the trigger;
  - otherwise flux_out rises after delay additional cycles.
- Pulse output: flux_out stays high for exactly PULSE_W cycles; pulses_sent increments on the rising edge.
- Overrun: a trigger arriving while delay or pulse is still active is dropped, overrun is set to 1, and the LFSR is not stepped.
- Transitions:
  - PREAMBLE → DATA on the carry that completes cell PREAMBLE_CELLS−1.
  - If cell_count_l = 0, DATA never self-terminates.
  - DATA → DRAIN on the carry that completes data cell cell_count_l−1; the NCO stops in DRAIN.
  - DRAIN → IDLE once delay/pulse is idle; done pulses on that edge.
- abort (any busy state) → IDLE on the next edge:
  - flux_out forced 0 on that edge; pending delay cancelled;
  - done not asserted; counters hold their values.
- abort and start in the same cycle in IDLE: abort wins, start ignored.
- reset mid-operation: immediate return to all reset values.
- Counters saturate at 32'hFFFF_FFFF (no wrap).

Decomposition:
- Package flux_stim_pkg: state encodings, LFSR mask 16'hB400, jitter width limit (4), freq_word clamp limits.
- One sub-module, stim_lfsr16 (seed load, step enable, 16-bit state out). The NCO and FSM stay in the top module.

Test Plan:
- Preamble timing: freq_word=0x0800_0000 (32-clk cells), jitter_sel=0, cell_count=16, pattern=0x4489.
  - flux_out rising edges exactly 64 clk apart during the preamble, first at start+17.
  - pulses_sent=37, cells_sent=80, done one cycle after the last pulse ends.
- Jitter window: same rate, jitter_sel=3.
  - Every rising edge lies within 0..7 clk after its nominal midpoint+1.
  - 1000 pulses cover all 8 offsets; overrun=0.
- Overrun: freq_word=0x4000_0000 (4-clk cells), pattern=0xFFFF, jitter_sel=4.
  - overrun=1; pulses_sent < number of 1-cells; flux_out high intervals always exactly PULSE_W.
- Abort: cell_count=0, abort at cycle 500.
  - IDLE and flux_out=0 the next cycle; done never pulses; cells_sent holds ≈15.
- Start handling: start pulsed while busy → counters and config unchanged.
  - Second start after done → counters and overrun cleared, identical pulse sequence (same LFSR seed).
- Reset/clamp: reset asserted mid-DATA → all outputs 0, IDLE next cycle.
  - freq_word=0xFFFF_FFFF → behaves as 0x7FFF_FFFF (2-clk cells).
